// File: rtl/rsp_s1_prep_ahbic_arbiter_if.sv
// Bus bundle between AHB-Lite masters, the slave-port mux and the arbiter.
// The slave modport is the arbiter's view; master is the surrounding fabric.
interface rsp_s1_prep_ahbic_arbiter_if #(
    parameter int NUM_MASTERS = 3,
    parameter int IDX_W       = 2
);
    logic [2*NUM_MASTERS-1:0] HTRANS_M;
    logic [NUM_MASTERS-1:0]   HMASTLOCK_M;
    logic                     HREADY;
    logic [1:0]               HTRANS_S;
    logic                     HMASTLOCK_S;
    logic [IDX_W-1:0]         ADDR_SEL;
    logic [IDX_W-1:0]         DATA_SEL;
    logic                     DATA_VALID;
    logic [NUM_MASTERS-1:0]   WAIT_M;

    modport slave (
        input  HTRANS_M, HMASTLOCK_M, HREADY,
        output HTRANS_S, HMASTLOCK_S, ADDR_SEL, DATA_SEL,
        output DATA_VALID, WAIT_M
    );

    modport master (
        output HTRANS_M, HMASTLOCK_M, HREADY,
        input  HTRANS_S, HMASTLOCK_S, ADDR_SEL, DATA_SEL,
        input  DATA_VALID, WAIT_M
    );
endinterface

// File: rtl/rsp_s1_prep_ahbic_arbiter.sv
// Round-robin AHB-Lite arbiter with burst and lock hold.
// Owner/data-phase indices are registered and frozen while HREADY is low.
module rsp_s1_prep_ahbic_arbiter #(
    parameter int NUM_MASTERS = 3,
    parameter int IDX_W       = 2
) (
    input logic HCLK,
    input logic HRESETn,
    rsp_s1_prep_ahbic_arbiter_if.slave bus
);
    logic [IDX_W-1:0]       addr_q;
    logic [IDX_W-1:0]       data_q;
    logic                   dv_q;
    logic                   lock_q;
    logic [IDX_W-1:0]       rr_q;
    logic [IDX_W-1:0]       nxt;
    logic [IDX_W-1:0]       cand;
    logic [NUM_MASTERS-1:0] req;
    logic [NUM_MASTERS-1:0] wait_m;
    logic [1:0]             htrans_s;
    logic                   lock_s;
    logic                   hold;
    int                     c;

    always_comb begin
        req      = '0;
        wait_m   = '0;
        htrans_s = 2'b00;
        lock_s   = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            req[i]    = bus.HTRANS_M[2*i+1];
            wait_m[i] = req[i] && (addr_q != IDX_W'(i));
            if (addr_q == IDX_W'(i)) begin
                htrans_s = bus.HTRANS_M[2*i +: 2];
                lock_s   = bus.HMASTLOCK_M[i];
            end
        end
    end

    // Walk candidates farthest-first so the nearest requester wins;
    // the owner itself is the last candidate (k = NUM_MASTERS).
    always_comb begin
        nxt  = addr_q;
        cand = '0;
        c    = 0;
        for (int k = NUM_MASTERS; k >= 1; k--) begin
            c = int'(rr_q) + k;
            if (c >= NUM_MASTERS) c = c - NUM_MASTERS;
            cand = IDX_W'(c);
            for (int j = 0; j < NUM_MASTERS; j++) begin
                if (cand == IDX_W'(j) && req[j]) nxt = cand;
            end
        end
    end

    // lock_q keeps the owner one extra edge after lock drops.
    assign hold = (htrans_s == 2'b11) || (htrans_s == 2'b01)
                || lock_s || lock_q;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_q <= '0;
            data_q <= '0;
            dv_q   <= 1'b0;
            lock_q <= 1'b0;
            rr_q   <= '0;
        end else if (bus.HREADY) begin
            data_q <= addr_q;
            dv_q   <= htrans_s[1];
            lock_q <= lock_s;
            if (!hold) begin
                addr_q <= nxt;
                rr_q   <= nxt;
            end
        end
    end

    assign bus.HTRANS_S    = htrans_s;
    assign bus.HMASTLOCK_S = lock_s;
    assign bus.ADDR_SEL    = addr_q;
    assign bus.DATA_SEL    = data_q;
    assign bus.DATA_VALID  = dv_q;
    assign bus.WAIT_M      = wait_m;
endmodule

// File: tb/tb_rsp_s1_prep_ahbic_arbiter.sv
// Directed bench for the round-robin AHB-Lite arbiter.
// Expected values are hand-derived from the arbitration rules.
module tb_rsp_s1_prep_ahbic_arbiter;
    localparam logic [1:0] IDL = 2'b00;
    localparam logic [1:0] NSQ = 2'b10;
    localparam logic [1:0] SQ  = 2'b11;

    logic HCLK;
    logic HRESETn;
    int   n_run;
    int   n_fail;

    rsp_s1_prep_ahbic_arbiter_if #(.NUM_MASTERS(3), .IDX_W(2)) bus ();

    rsp_s1_prep_ahbic_arbiter #(.NUM_MASTERS(3), .IDX_W(2)) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drv(input logic [1:0] t2, input logic [1:0] t1,
                       input logic [1:0] t0, input logic [2:0] lk);
        bus.HTRANS_M    = {t2, t1, t0};
        bus.HMASTLOCK_M = lk;
    endtask

    task automatic regs(input string tag, input logic [1:0] a,
                        input logic [1:0] d, input logic v);
        chk({tag, "_addr"}, 8'(bus.ADDR_SEL), 8'(a));
        chk({tag, "_data"}, 8'(bus.DATA_SEL), 8'(d));
        chk({tag, "_dv"},   8'(bus.DATA_VALID), 8'(v));
    endtask

    logic [1:0] rot [6];
    logic [1:0] prev;

    initial begin
        n_run   = 0;
        n_fail  = 0;
        HRESETn = 1'b0;
        bus.HREADY = 1'b1;
        drv(IDL, IDL, IDL, 3'b000);
        #12;
        regs("rst", 2'd0, 2'd0, 1'b0);
        chk("rst_wait", 8'(bus.WAIT_M), 8'h0);
        @(negedge HCLK);
        HRESETn = 1'b1;

        drv(NSQ, NSQ, IDL, 3'b000);
        #1;
        chk("g1_wait_pre", 8'(bus.WAIT_M), 8'b110);
        chk("g1_htrans_pre", 8'(bus.HTRANS_S), 8'(IDL));
        tick();
        regs("g1", 2'd1, 2'd0, 1'b0);
        chk("g1_wait", 8'(bus.WAIT_M), 8'b100);
        chk("g1_htrans", 8'(bus.HTRANS_S), 8'(NSQ));
        tick();
        regs("g2", 2'd2, 2'd1, 1'b1);
        drv(IDL, IDL, IDL, 3'b000);
        tick();
        regs("park", 2'd2, 2'd2, 1'b0);

        drv(IDL, IDL, NSQ, 3'b000);
        tick();
        regs("b_grant", 2'd0, 2'd2, 1'b0);
        tick();
        regs("b_beat1", 2'd0, 2'd0, 1'b1);
        drv(IDL, NSQ, SQ, 3'b000);
        #1;
        chk("b_wait", 8'(bus.WAIT_M), 8'b010);
        for (int i = 0; i < 3; i++) begin
            tick();
            regs("b_seq", 2'd0, 2'd0, 1'b1);
        end
        drv(IDL, NSQ, IDL, 3'b000);
        tick();
        regs("b_end", 2'd1, 2'd0, 1'b0);

        drv(NSQ, NSQ, IDL, 3'b000);
        bus.HREADY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            regs("stall", 2'd1, 2'd0, 1'b0);
        end
        bus.HREADY = 1'b1;
        tick();
        regs("stall_rel", 2'd2, 2'd1, 1'b1);

        drv(IDL, IDL, IDL, 3'b000);
        tick();
        regs("l_park", 2'd2, 2'd2, 1'b0);
        drv(NSQ, NSQ, NSQ, 3'b100);
        #1;
        chk("l_lock_s", 8'(bus.HMASTLOCK_S), 8'h1);
        chk("l_wait", 8'(bus.WAIT_M), 8'b011);
        tick();
        regs("l_xfer1", 2'd2, 2'd2, 1'b1);
        tick();
        regs("l_xfer2", 2'd2, 2'd2, 1'b1);
        drv(IDL, NSQ, NSQ, 3'b000);
        tick();
        regs("l_tail", 2'd2, 2'd2, 1'b0);
        tick();
        regs("l_rel", 2'd0, 2'd2, 1'b0);

        drv(NSQ, NSQ, NSQ, 3'b000);
        rot[0] = 2'd1; rot[1] = 2'd2; rot[2] = 2'd0;
        rot[3] = 2'd1; rot[4] = 2'd2; rot[5] = 2'd0;
        prev = 2'd0;
        for (int i = 0; i < 6; i++) begin
            tick();
            regs($sformatf("rr%0d", i), rot[i], prev, 1'b1);
            prev = rot[i];
        end

        tick();
        tick();
        chk("r_own2", 8'(bus.ADDR_SEL), 8'd2);
        drv(SQ, NSQ, NSQ, 3'b000);
        tick();
        chk("r_burst", 8'(bus.ADDR_SEL), 8'd2);
        #2;
        HRESETn = 1'b0;
        #1;
        regs("r_async", 2'd0, 2'd0, 1'b0);
        chk("r_htrans", 8'(bus.HTRANS_S), 8'(NSQ));
        chk("r_wait", 8'(bus.WAIT_M), 8'b110);
        @(negedge HCLK);
        HRESETn = 1'b1;
        drv(NSQ, NSQ, IDL, 3'b000);
        tick();
        regs("r_restart", 2'd1, 2'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/rsp_s1_prep_ahbic_arbiter.md
RSP_S1_PREP_AHBIC_ARBITER -- requirements
Module: rsp_s1_prep_ahbic_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 3, number of AHB-Lite masters sharing the slave port (2..4).
REQ-002 SHALL have parameter IDX_W, default 2, width of master index fields.
REQ-003 SHALL have port HCLK, input, 1, AHB system clock; the block uses one clock.
REQ-004 SHALL have port HRESETn, input, 1, AHB system reset; reset is asynchronous and active-low.
REQ-005 SHALL have port HTRANS_M, input, 2*NUM_MASTERS, per-master HTRANS; master i occupies bits [2i+1:2i].
REQ-006 SHALL have port HMASTLOCK_M, input, NUM_MASTERS, per-master lock request.
REQ-007 SHALL have port HREADY, input, 1, shared transfer-done from the slave-side mux.
REQ-008 SHALL have port HTRANS_S, output, 2, HTRANS of the current address-phase owner.
REQ-009 SHALL have port HMASTLOCK_S, output, 1, lock of the current address-phase owner.
REQ-010 SHALL have port ADDR_SEL, output, IDX_W, registered address-phase owner index that drives the address/control mux.
REQ-011 SHALL have port DATA_SEL, output, IDX_W, registered data-phase owner index that drives the HWDATA and response routing.
REQ-012 SHALL have port DATA_VALID, output, 1, high when the current data phase belongs to a real NONSEQ/SEQ transfer.
REQ-013 SHALL have port WAIT_M, output, NUM_MASTERS, per-master stall; it drives that master's HREADY low.

Function
REQ-014 SHALL treat master i as requesting when HTRANS_M[i] bit 1 is 1 (NONSEQ or SEQ).
REQ-015 SHALL drive HTRANS_S = HTRANS_M[ADDR_SEL] and HMASTLOCK_S = HMASTLOCK_M[ADDR_SEL] combinationally.
REQ-016 SHALL drive WAIT_M[i] = requesting(i) AND (ADDR_SEL != i) combinationally; WAIT_M[ADDR_SEL] = 0.
REQ-017 SHALL hold state (ADDR_SEL, DATA_SEL, DATA_VALID, RR pointer, lock flag) unchanged on any edge where HREADY = 0.
REQ-018 SHALL, on an edge with HREADY = 1, load DATA_SEL <= ADDR_SEL and DATA_VALID <= HTRANS_S bit 1.
REQ-019 SHALL keep the owner (no re-arbitration) on an HREADY = 1 edge when HTRANS_S is SEQ (2'b11) or BUSY (2'b01), i.e. a burst is in progress.
REQ-020 SHALL keep the owner while HMASTLOCK_S = 1, and for one further HREADY = 1 edge after lock deasserts, so that the locked sequence's last data phase completes first (lock flag).
REQ-021 SHALL otherwise re-arbitrate round-robin on an HREADY = 1 edge, searching from index (ADDR_SEL+1) mod NUM_MASTERS and granting the first requesting master; the owner itself has the lowest priority.
REQ-022 SHALL park on the current ADDR_SEL when no master requests.
REQ-023 SHALL, with simultaneous requests, grant strictly by RR order; no master waits more than NUM_MASTERS-1 grants once the owner releases.
REQ-024 SHALL change ADDR_SEL only at a clock edge; the new owner's first transfer appears on HTRANS_S in the cycle after the decision, with one cycle of grant latency.
REQ-025 SHALL treat HTRANS_M values for indices >= NUM_MASTERS as never requesting; ADDR_SEL never exceeds NUM_MASTERS-1.
REQ-026 SHALL not alter arbitration on an ERROR response; masters cancel to IDLE per AHB-Lite, which releases the bus under REQ-021.

Reset
REQ-027 SHALL, while HRESETn = 0, force ADDR_SEL = 0, DATA_SEL = 0, DATA_VALID = 0, lock flag = 0, and RR pointer = 0, asynchronously.
REQ-028 SHALL, on a reset mid-burst or mid-lock, discard the ownership; after release, master 0 owns the bus and arbitration restarts from index 1.
REQ-029 SHALL have WAIT_M and HTRANS_S follow REQ-015/REQ-016 combinationally from the reset state (ADDR_SEL = 0).

Verification
REQ-030 SHALL cover: after reset, M1 and M2 NONSEQ with HREADY = 1 -> next cycle ADDR_SEL = 1, WAIT_M = 3'b100; after M1 goes IDLE -> ADDR_SEL = 2.
REQ-031 SHALL cover: M0 INCR4 (NONSEQ, SEQ x3) with M1 requesting throughout -> ADDR_SEL stays 0 for 4 accepted beats, then 1; DATA_SEL lags ADDR_SEL by one accepted beat.
REQ-032 SHALL cover: HREADY held 0 for 3 cycles during a grant change -> ADDR_SEL, DATA_SEL and DATA_VALID are frozen; the change completes on the first HREADY = 1 edge.
REQ-033 SHALL cover: M2 HMASTLOCK = 1 over 2 NONSEQ transfers with M0/M1 requesting -> M2 is held for both transfers plus one edge after lock drops, and only then is M0 granted.
REQ-034 SHALL cover: all 3 masters requesting continuously with single transfers -> grant sequence 1,2,0,1,2,0 with no starvation.
REQ-035 SHALL cover: HRESETn asserted mid-burst on M2 -> outputs return to reset values immediately, with no clock edge required.
